fetch_unit: RTL and testbench

Instruction-fetch stage, directly upstream of `branching`. Holds the PC, issues one instruction-memory request at a time, and registers the IF/DEC pipeline outputs. These outputs (`PCIF`, `instrIF`, `validIF`) feed decode and `branching`. Consumes `branching_out` to redirect, stall or squash, so fetch steering lives in one place.

---
 rtl/core_types_pkg.sv | 37 +++
 rtl/fetch_unit_if.sv | 20 ++
 rtl/fetch_next_pc.sv | 42 ++++
 rtl/fetch_unit.sv | 170 +++++++++++++++++
 tb/tb_fetch_unit.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/core_types_pkg.sv
// ---------------------------------------------------------------------------
// core_types_pkg
// Shared core types. Holds the branching_out_t record produced by the
// branching stage and the fetch-stage types consumed by fetch_unit.
//   branching_out_t : flush / hold / branch / bypass / PCnext / PCcurrent
//   fetch_state_t   : fetch FSM states
//   ifdec_action_t  : what the IF/DEC register does on the next edge
//   NOP_INSTR       : instruction placed in IF/DEC for bubbles
// ---------------------------------------------------------------------------
package core_types_pkg;

  typedef struct packed {
    logic        flush;
    logic        hold;
    logic        branch;
    logic        bypass;
    logic [31:0] PCnext;
    logic [31:0] PCcurrent;
  } branching_out_t;

  typedef enum logic [1:0] {
    ISSUE,
    WAIT,
    STALL,
    DISCARD
  } fetch_state_t;

  typedef enum logic [1:0] {
    IFDEC_KEEP,
    IFDEC_BUBBLE,
    IFDEC_LOAD_MEM,
    IFDEC_LOAD_BUF
  } ifdec_action_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_unit_if.sv
// ---------------------------------------------------------------------------
// fetch_unit_if
// Instruction-memory request/response bus between fetch_unit and imem.
//   req    : request valid (fetch -> mem)
//   addr   : request word address (fetch -> mem)
//   gnt    : memory accepts the request this cycle (mem -> fetch)
//   rvalid : read data valid, at least one cycle after gnt (mem -> fetch)
//   rdata  : instruction word (mem -> fetch)
// Modports: master = fetch side, slave = memory side.
// ---------------------------------------------------------------------------
interface fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, output addr, input gnt, input rvalid, input rdata);
  modport slave  (input req, input addr, output gnt, output rvalid, output rdata);
endinterface

// File: rtl/fetch_next_pc.sv
// ---------------------------------------------------------------------------
// fetch_next_pc
// Combinational next-PC selection, kept separate so prediction logic can
// reuse it later.
//   pc               in  current fetch PC
//   branchingOut     in  record from the branching stage
//   redirect         out bypass | branch
//   targetPc         out redirect target with bits [1:0] cleared
//   pcPlus4          out sequential successor (wraps at 2^32)
//   targetMisaligned out raw target had bits [1:0] set
//                        (only with FETCH_MISALIGN_CHECK_EN)
// ---------------------------------------------------------------------------
module fetch_next_pc
  import core_types_pkg::*;
(
  input  logic [31:0]    pc,
  input  branching_out_t branchingOut,
  output logic           redirect,
  output logic [31:0]    targetPc,
  output logic [31:0]    pcPlus4
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic           targetMisaligned
`endif
);

  logic [31:0] rawTarget;

  // Bypass is an absolute address and wins over a PC-relative branch.
  always_comb begin
    rawTarget = branchingOut.bypass ? branchingOut.PCnext
                                    : branchingOut.PCcurrent + branchingOut.PCnext;
    redirect  = branchingOut.bypass | branchingOut.branch;
    targetPc  = rawTarget & ~32'd3;
    pcPlus4   = pc + 32'd4;
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  assign targetMisaligned = |rawTarget[1:0];
`endif

endmodule

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch stage. Holds the PC, keeps at most one imem request in
// flight and registers the IF/DEC outputs. All steering (redirect, hold,
// flush) comes from the branching stage via branching_out.
// Ports:
//   Clock, Reset    core clock, asynchronous active-high reset
//   branching_out   flush / hold / branch / bypass / PCnext / PCcurrent
//   imem            fetch_unit_if.master instruction-memory bus
//   PCIF            address of instrIF
//   instrIF         fetched instruction, NOP_INSTR when validIF = 0
//   validIF         instrIF is a real instruction
//   misalignIF      redirect target was misaligned
//                   (only with FETCH_MISALIGN_CHECK_EN)
// Parameter: RESET_VECTOR, first fetch address after reset.
// ---------------------------------------------------------------------------
module fetch_unit
  import core_types_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic           Clock,
  input  logic           Reset,
  input  branching_out_t branching_out,
  fetch_unit_if.master   imem,
  output logic [31:0]    PCIF,
  output logic [31:0]    instrIF,
  output logic           validIF
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic           misalignIF
`endif
);

  fetch_state_t  state, stateNext;
  ifdec_action_t ifdecAction;
  logic [31:0]   pc, pcNext, buffer, targetPc, pcPlus4;
  logic          redirect, kill, hold, flush, issueReq, grant, bufferWrite;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic          targetMisaligned;
`endif

  fetch_next_pc nextPcSel (
    .pc              (pc),
    .branchingOut    (branching_out),
    .redirect        (redirect),
    .targetPc        (targetPc),
    .pcPlus4         (pcPlus4)
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    .targetMisaligned(targetMisaligned)
`endif
  );

  assign hold  = branching_out.hold;
  assign flush = branching_out.flush;
  assign kill  = flush | redirect;

  // Request is masked during reset so memory never sees a pre-reset request.
  assign issueReq  = (state == ISSUE) && !hold && !Reset;
  assign grant     = issueReq && imem.gnt;
  assign imem.req  = issueReq;
  assign imem.addr = pc;

  // Next state, next PC and IF/DEC action. Redirect outranks hold; a flush
  // that lands on arriving or buffered data drops it and refetches the
  // same PC, since the data cannot enter IF/DEC this cycle.
  always_comb begin
    stateNext   = state;
    pcNext      = pc;
    bufferWrite = 1'b0;
    ifdecAction = (kill || !hold) ? IFDEC_BUBBLE : IFDEC_KEEP;
    unique case (state)
      ISSUE: begin
        if (redirect) pcNext = targetPc;
        if (grant) stateNext = redirect ? DISCARD : WAIT;
      end
      WAIT: begin
        if (redirect) begin
          pcNext    = targetPc;
          stateNext = imem.rvalid ? ISSUE : DISCARD;
        end else if (imem.rvalid) begin
          if (flush) begin
            stateNext = ISSUE;
          end else if (hold) begin
            bufferWrite = 1'b1;
            stateNext   = STALL;
          end else begin
            ifdecAction = IFDEC_LOAD_MEM;
            pcNext      = pcPlus4;
            stateNext   = ISSUE;
          end
        end
      end
      STALL: begin
        if (redirect) begin
          pcNext    = targetPc;
          stateNext = ISSUE;
        end else if (hold) begin
          stateNext = STALL;
        end else if (flush) begin
          stateNext = ISSUE;
        end else begin
          ifdecAction = IFDEC_LOAD_BUF;
          pcNext      = pcPlus4;
          stateNext   = ISSUE;
        end
      end
      DISCARD: begin
        if (redirect) pcNext = targetPc;
        if (imem.rvalid) stateNext = ISSUE;
      end
      default: stateNext = ISSUE;
    endcase
  end

  // FSM, PC and the hold buffer for data that arrived while held.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state  <= ISSUE;
      pc     <= RESET_VECTOR;
      buffer <= 32'd0;
    end else begin
      state <= stateNext;
      pc    <= pcNext;
      if (bufferWrite) buffer <= imem.rdata;
    end
  end

  // IF/DEC register; PC is frozen in STALL so it still names the buffer.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      PCIF    <= 32'd0;
      instrIF <= NOP_INSTR;
      validIF <= 1'b0;
    end else begin
      unique case (ifdecAction)
        IFDEC_BUBBLE: begin
          instrIF <= NOP_INSTR;
          validIF <= 1'b0;
        end
        IFDEC_LOAD_MEM: begin
          PCIF    <= pc;
          instrIF <= imem.rdata;
          validIF <= 1'b1;
        end
        IFDEC_LOAD_BUF: begin
          PCIF    <= pc;
          instrIF <= buffer;
          validIF <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  // Set together with the redirect bubble, cleared by the next real load.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      misalignIF <= 1'b0;
    end else if (redirect && targetMisaligned) begin
      misalignIF <= 1'b1;
    end else if (ifdecAction == IFDEC_LOAD_MEM || ifdecAction == IFDEC_LOAD_BUF) begin
      misalignIF <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
// Self-checking bench for fetch_unit with RESET_VECTOR = 0x100 and a
// one-cycle instruction memory. Expected IF/DEC loads are queued when the
// stimulus makes them inevitable and popped when validIF shows a new load.
// Misalign checks are active when FETCH_MISALIGN_CHECK_EN is defined.
// ---------------------------------------------------------------------------
module tb_fetch_unit;
  import core_types_pkg::*;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } expEntry_t;

  logic           Clock;
  logic           Reset;
  branching_out_t bo;
  logic [31:0]    PCIF, instrIF;
  logic           validIF;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic           misalignIF;
`endif

  fetch_unit_if imemBus ();

  fetch_unit #(.RESET_VECTOR(32'h0000_0100)) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .branching_out(bo),
    .imem         (imemBus),
    .PCIF         (PCIF),
    .instrIF      (instrIF),
    .validIF      (validIF)
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    .misalignIF   (misalignIF)
`endif
  );

  int          checkCount = 0;
  int          failCount  = 0;
  expEntry_t   expQ[$];
  logic        memGntEn;
  logic [31:0] overrideAddr, overrideData;
  int          grantCount;
  logic        lastHold;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a == overrideAddr) ? overrideData : (a ^ 32'h5A5A_0013);
  endfunction

  // Memory: grants whenever enabled, returns data exactly one cycle later.
  assign imemBus.gnt = memGntEn;
  always @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      imemBus.rvalid <= 1'b0;
      imemBus.rdata  <= 32'd0;
      grantCount     <= 0;
      lastHold       <= 1'b0;
    end else begin
      imemBus.rvalid <= imemBus.req & imemBus.gnt;
      imemBus.rdata  <= memWord(imemBus.addr);
      if (imemBus.req && imemBus.gnt) grantCount <= grantCount + 1;
      lastHold <= bo.hold;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // A fresh load is visible when validIF is set and the last edge had no hold.
  always @(negedge Clock) begin
    if (!Reset && validIF && !lastHold) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpectedValid", {31'd0, validIF}, 32'd0);
      end else begin
        expEntry_t e;
        e = expQ.pop_front();
        checkOutput("PCIF", PCIF, e.pc);
        checkOutput("instrIF", instrIF, e.instr);
      end
    end
  end

  task automatic nextCycle();
    @(negedge Clock);
  endtask

  task automatic applyStimulus(input logic flush, input logic hold, input logic branch,
                               input logic bypass, input logic [31:0] pcNext,
                               input logic [31:0] pcCurrent);
    bo.flush     = flush;
    bo.hold      = hold;
    bo.branch    = branch;
    bo.bypass    = bypass;
    bo.PCnext    = pcNext;
    bo.PCcurrent = pcCurrent;
  endtask

  task automatic pushExpected(input logic [31:0] a);
    expEntry_t e;
    e.pc    = a;
    e.instr = memWord(a);
    expQ.push_back(e);
  endtask

  // Reset, check reset values, release; returns mid-cycle of the first cycle.
  task automatic applyReset();
    @(negedge Clock);
    Reset        = 1'b1;
    memGntEn     = 1'b1;
    overrideAddr = 32'hFFFF_FFF0;
    overrideData = 32'd0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    expQ.delete();
    repeat (2) nextCycle();
    checkOutput("rstReq", {31'd0, imemBus.req}, 32'd0);
    checkOutput("rstAddr", imemBus.addr, 32'h100);
    checkOutput("rstPCIF", PCIF, 32'd0);
    checkOutput("rstInstr", instrIF, NOP_INSTR);
    checkOutput("rstValid", {31'd0, validIF}, 32'd0);
`ifdef FETCH_MISALIGN_CHECK_EN
    checkOutput("rstMisalign", {31'd0, misalignIF}, 32'd0);
`endif
    Reset = 1'b0;
    #1;
  endtask

  task automatic drainAndCheck(input int n);
    repeat (n) nextCycle();
    #1;
    checkOutput("scoreboardEmpty", expQ.size(), 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    Reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    memGntEn = 1'b1;
    overrideAddr = 32'hFFFF_FFF0;
    overrideData = 32'd0;

    // Sequential fetch: addresses 0x100, 0x104, 0x108, one load per 2 cycles.
    applyReset();
    checkOutput("firstReq", {31'd0, imemBus.req}, 32'd1);
    checkOutput("addr100", imemBus.addr, 32'h100);
    pushExpected(32'h100);
    nextCycle();
    nextCycle();
    checkOutput("addr104", imemBus.addr, 32'h104);
    pushExpected(32'h104);
    nextCycle();
    nextCycle();
    checkOutput("addr108", imemBus.addr, 32'h108);
    pushExpected(32'h108);
    nextCycle();
    memGntEn = 1'b0;
    drainAndCheck(4);
    checkOutput("noGntAddr", imemBus.addr, 32'h10C);
    checkOutput("noGntReq", {31'd0, imemBus.req}, 32'd1);

    // Relative branch while waiting: stale data dropped, fetch from 0x240.
    applyReset();
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h40, 32'h200);
    nextCycle();
    checkOutput("brBubble", {31'd0, validIF}, 32'd0);
    checkOutput("brAddr", imemBus.addr, 32'h240);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    #1;
    checkOutput("brReq", {31'd0, imemBus.req}, 32'd1);
    pushExpected(32'h240);
    nextCycle();
    memGntEn = 1'b0;
    drainAndCheck(4);

    // Bypass together with hold: redirect wins, hold is ignored.
    applyReset();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 32'h1234, 32'd0);
    #1;
    checkOutput("holdMasksReq", {31'd0, imemBus.req}, 32'd0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    #1;
    checkOutput("bypassAddr", imemBus.addr, 32'h1234);
    checkOutput("bypassReq", {31'd0, imemBus.req}, 32'd1);
    pushExpected(32'h1234);
    nextCycle();
    memGntEn = 1'b0;
    drainAndCheck(4);

    // Hold when data arrives: IF/DEC frozen 3 cycles, then buffered word.
    applyReset();
    overrideAddr = 32'h100;
    overrideData = 32'hDEAD_BEEF;
    nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    pushExpected(32'h100);
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      checkOutput("holdValid", {31'd0, validIF}, 32'd0);
      checkOutput("holdPCIF", PCIF, 32'd0);
      checkOutput("holdNoReq", {31'd0, imemBus.req}, 32'd0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    nextCycle();
    #1;
    checkOutput("afterHoldAddr", imemBus.addr, 32'h104);
    checkOutput("grantCount", grantCount, 32'd1);
    memGntEn = 1'b0;
    drainAndCheck(3);

    // Flush only: IF/DEC squashed, PC unchanged, same address refetched.
    applyReset();
    nextCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    nextCycle();
    checkOutput("flushBubble", {31'd0, validIF}, 32'd0);
    checkOutput("flushAddr", imemBus.addr, 32'h100);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    #1;
    checkOutput("flushReq", {31'd0, imemBus.req}, 32'd1);
    pushExpected(32'h100);
    nextCycle();
    memGntEn = 1'b0;
    drainAndCheck(4);

    // Redirect on a granted request goes through DISCARD; PC wraps to 0.
    applyReset();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'd0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    #1;
    checkOutput("discardNoReq", {31'd0, imemBus.req}, 32'd0);
    checkOutput("wrapTarget", imemBus.addr, 32'hFFFF_FFFC);
    nextCycle();
    checkOutput("afterDiscardReq", {31'd0, imemBus.req}, 32'd1);
    pushExpected(32'hFFFF_FFFC);
    nextCycle();
    nextCycle();
    checkOutput("wrapAddr", imemBus.addr, 32'd0);
    checkOutput("wrapReq", {31'd0, imemBus.req}, 32'd1);
    memGntEn = 1'b0;
    drainAndCheck(3);

    // Misaligned bypass target: low bits cleared, flagged with the macro.
    applyReset();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 32'h302, 32'd0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    #1;
    checkOutput("misalignAddr", imemBus.addr, 32'h300);
`ifdef FETCH_MISALIGN_CHECK_EN
    checkOutput("misalignSet", {31'd0, misalignIF}, 32'd1);
`endif
    pushExpected(32'h300);
    nextCycle();
    memGntEn = 1'b0;
    nextCycle();
`ifdef FETCH_MISALIGN_CHECK_EN
    checkOutput("misalignClear", {31'd0, misalignIF}, 32'd0);
`endif
    drainAndCheck(3);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
